// File: rtl/mips32_mdu_pkg.sv
// Shared definitions for the MIPS32 multiply/divide unit: op encoding,
// FSM state encoding and the default datapath width.
package mips32_mdu_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    OP_MULTU = 3'd0,
    OP_MULT  = 3'd1,
    OP_DIVU  = 3'd2,
    OP_DIV   = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mips32_mdu_step.sv
// One iteration of the MDU datapath: shift-add multiply or restoring
// shift-subtract divide, selected by div_mode.
module mips32_mdu_step
  import mips32_mdu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            div_mode,
  input  logic [XLEN-1:0] acc,
  input  logic [XLEN-1:0] low,
  input  logic [XLEN-1:0] operand,
  output logic [XLEN-1:0] acc_nxt,
  output logic [XLEN-1:0] low_nxt
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;

  always_comb begin
    sum     = {1'b0, acc} + (low[0] ? {1'b0, operand} : '0);
    // Partial remainder is XLEN+1 bits wide; the top bit of trial is the borrow.
    shifted = {acc, low[XLEN-1]};
    trial   = shifted - {1'b0, operand};
    if (div_mode) begin
      if (!trial[XLEN]) begin
        acc_nxt = trial[XLEN-1:0];
        low_nxt = {low[XLEN-2:0], 1'b1};
      end else begin
        acc_nxt = shifted[XLEN-1:0];
        low_nxt = {low[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_nxt = sum[XLEN:1];
      low_nxt = {sum[0], low[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/mips32_mdu.sv
// Iterative multiply/divide unit holding HI/LO. Busy_EX stalls EX while
// iterating; Done_EX pulses the cycle HI/LO show a new result.
module mips32_mdu
  import mips32_mdu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start_EX,
  input  logic [2:0]      Op_EX,
  input  logic [XLEN-1:0] Operand_A_EX,
  input  logic [XLEN-1:0] Operand_B_EX,
  output logic            Busy_EX,
  output logic            Done_EX,
  output logic            Div_By_Zero_EX,
  output logic [XLEN-1:0] HI_EX,
  output logic [XLEN-1:0] LO_EX,
  output logic [1:0]      State_Dbg_EX
);

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] ITER = ST_ITER;
  localparam logic [1:0] FIX  = ST_FIX;
  localparam int CW = $clog2(XLEN);

  logic [1:0]      state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] acc, low, opnd;
  logic [XLEN-1:0] acc_nxt, low_nxt;
  logic            div_mode, res_neg, rem_neg, dbz;

  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_abs, b_abs;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0] quo_fix, rem_fix;

  assign State_Dbg_EX = state;

  // Magnitudes are only taken for the signed ops (odd op codes).
  always_comb begin
    a_neg    = Op_EX[0] & Operand_A_EX[XLEN-1];
    b_neg    = Op_EX[0] & Operand_B_EX[XLEN-1];
    a_abs    = a_neg ? -Operand_A_EX : Operand_A_EX;
    b_abs    = b_neg ? -Operand_B_EX : Operand_B_EX;
    prod_fix = res_neg ? -{acc, low} : {acc, low};
    quo_fix  = res_neg ? -low : low;
    rem_fix  = rem_neg ? -acc : acc;
  end

  mips32_mdu_step #(.XLEN(XLEN)) u_step (
    .div_mode (div_mode),
    .acc      (acc),
    .low      (low),
    .operand  (opnd),
    .acc_nxt  (acc_nxt),
    .low_nxt  (low_nxt)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state          <= IDLE;
      cnt            <= '0;
      acc            <= '0;
      low            <= '0;
      opnd           <= '0;
      div_mode       <= 1'b0;
      res_neg        <= 1'b0;
      rem_neg        <= 1'b0;
      dbz            <= 1'b0;
      Busy_EX        <= 1'b0;
      Done_EX        <= 1'b0;
      Div_By_Zero_EX <= 1'b0;
      HI_EX          <= '0;
      LO_EX          <= '0;
    end else begin
      Done_EX        <= 1'b0;
      Div_By_Zero_EX <= 1'b0;
      case (state)
        IDLE: begin
          if (Start_EX) begin
            if (!Op_EX[2]) begin
              div_mode <= Op_EX[1];
              res_neg  <= a_neg ^ b_neg;
              rem_neg  <= a_neg;
              dbz      <= Op_EX[1] && (Operand_B_EX == '0);
              cnt      <= '0;
              acc      <= '0;
              // Divide keeps the dividend in low and divisor as the operand;
              // multiply keeps the multiplier in low.
              opnd     <= Op_EX[1] ? b_abs : a_abs;
              low      <= Op_EX[1] ? a_abs : b_abs;
              Busy_EX  <= 1'b1;
              state    <= ITER;
            end else if (Op_EX == OP_MTHI) begin
              HI_EX   <= Operand_A_EX;
              Done_EX <= 1'b1;
            end else if (Op_EX == OP_MTLO) begin
              LO_EX   <= Operand_A_EX;
              Done_EX <= 1'b1;
            end
          end
        end
        ITER: begin
          acc <= acc_nxt;
          low <= low_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(XLEN-1)) state <= FIX;
        end
        FIX: begin
          if (div_mode) begin
            HI_EX <= rem_fix;
            LO_EX <= dbz ? '1 : quo_fix;
            Div_By_Zero_EX <= dbz;
          end else begin
            HI_EX <= prod_fix[2*XLEN-1:XLEN];
            LO_EX <= prod_fix[XLEN-1:0];
          end
          Done_EX <= 1'b1;
          Busy_EX <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips32_mdu.sv
// Bench for mips32_mdu: directed corner cases plus random ops compared
// against an arithmetic reference model through an expected queue.
module tb_mips32_mdu;
  import mips32_mdu_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] a, b;
  logic            busy, done, dbz;
  logic [XLEN-1:0] hi, lo;
  logic [1:0]      state_dbg;

  int checks = 0;
  int errors = 0;
  logic [2*XLEN:0] exp_q[$];
  logic [XLEN-1:0] hi_m, lo_m;

  mips32_mdu #(.XLEN(XLEN)) dut (
    .Clk            (clk),
    .Reset          (reset),
    .Start_EX       (start),
    .Op_EX          (op),
    .Operand_A_EX   (a),
    .Operand_B_EX   (b),
    .Busy_EX        (busy),
    .Done_EX        (done),
    .Div_By_Zero_EX (dbz),
    .HI_EX          (hi),
    .LO_EX          (lo),
    .State_Dbg_EX   (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural HI/LO.
  task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] p;
    logic dz;
    dz = 1'b0;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      3'd0: begin p = {32'b0, x} * {32'b0, y}; hi_m = p[63:32]; lo_m = p[31:0]; end
      3'd1: begin p = sx * sy; hi_m = p[63:32]; lo_m = p[31:0]; end
      3'd2, 3'd3: begin
        if (y == 32'd0) begin
          hi_m = x; lo_m = 32'hFFFF_FFFF; dz = 1'b1;
        end else if (o == 3'd2) begin
          lo_m = x / y; hi_m = x % y;
        end else begin
          q = sx / sy; r = sx % sy;
          lo_m = q[31:0]; hi_m = r[31:0];
        end
      end
      3'd4: hi_m = x;
      3'd5: lo_m = x;
      default: ;
    endcase
    exp_q.push_back({dz, hi_m, lo_m});
  endtask

  // ---------------- driver ----------------
  // Called at a negedge; returns at the negedge of the Done_EX cycle so the
  // next call issues back-to-back.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit collide);
    int cyc;
    logic [2*XLEN:0] e;
    model(o, x, y);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      if (collide && cyc == 5) begin
        start = 1'b1; op = OP_MULTU; a = $urandom; b = $urandom;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("busy_cycles", 64'(cyc), (o < 3'd4) ? 64'd33 : 64'd0);
    check("done", 64'(done), 64'd1);
    e = exp_q.pop_front();
    check("div_by_zero", 64'(dbz), 64'(e[2*XLEN]));
    check("hi", 64'(hi), 64'(e[2*XLEN-1:XLEN]));
    check("lo", 64'(lo), 64'(e[XLEN-1:0]));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int  seen;
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    hi_m = '0; lo_m = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_dbz", 64'(dbz), 64'd0);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    check("reset_state", 64'(state_dbg), 64'(ST_IDLE));
    reset = 1'b0;
    @(negedge clk);

    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("multu_max_hi", 64'(hi), 64'hFFFF_FFFE);
    check("multu_max_lo", 64'(lo), 64'h0000_0001);
    @(negedge clk);
    check("done_single_pulse", 64'(done), 64'd0);

    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0);
    check("mult_neg_lo", 64'(lo), 64'hFFFF_FFEB);
    run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0);
    run_op(OP_DIVU, 32'd7, 32'd2, 1'b0);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("div_neg_hi", 64'(hi), 64'hFFFF_FFFF);
    run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("div_ovf_lo", 64'(lo), 64'h8000_0000);
    run_op(OP_DIVU, 32'd5, 32'd0, 1'b0);
    run_op(OP_DIV, 32'hFFFF_FFF0, 32'd0, 1'b0);

    run_op(OP_MTHI, 32'h1234_5678, 32'd0, 1'b0);
    run_op(OP_MTLO, 32'h9ABC_DEF0, 32'd0, 1'b0);
    @(negedge clk);
    check("mt_done_clear", 64'(done), 64'd0);
    check("mt_hi_kept", 64'(hi), 64'h1234_5678);

    run_op(OP_MULTU, $urandom, $urandom, 1'b1);
    @(negedge clk);
    check("collide_no_extra_done", 64'(done), 64'd0);
    check("collide_idle", 64'(busy), 64'd0);

    start = 1'b1; op = 3'd6; a = $urandom; b = $urandom;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("reserved_done", 64'(done), 64'd0);
      check("reserved_busy", 64'(busy), 64'd0);
      @(negedge clk);
    end
    check("reserved_hi", 64'(hi), 64'(hi_m));
    check("reserved_lo", 64'(lo), 64'(lo_m));

    for (int i = 0; i < 24; i++) begin
      run_op(3'($urandom_range(0, 5)), pick(), pick(), 1'b0);
    end
    @(negedge clk);

    // Reset during a divide abandons it.
    start = 1'b1; op = OP_DIV; a = 32'hFFFF_FF9C; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    hi_m = '0; lo_m = '0;
    check("midreset_busy", 64'(busy), 64'd0);
    check("midreset_hi", 64'(hi), 64'd0);
    check("midreset_lo", 64'(lo), 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) seen++;
      @(negedge clk);
    end
    check("midreset_no_done", 64'(seen), 64'd0);
    run_op(OP_DIVU, 32'd100, 32'd7, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
